// File: rtl/monomial_compress_pipe_if.sv
// Handshake bundle between the monomial generators, the compression pipe and
// the S-box output reconstruction stage.
interface monomial_compress_pipe_if #(
  parameter int W     = 15,
  parameter int N_IN  = 8,
  parameter int N_OUT = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N_IN*W-1:0]     in_vec;
  logic                  out_valid;
  logic                  out_ready;
  logic [N_OUT*W-1:0]    out_vec;
  logic [1:0]            occupancy;

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_vec, occupancy
  );

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_vec, occupancy
  );
endinterface

// File: rtl/monomial_compress_pipe.sv
// Two-stage valid/ready pipe: a plain register barrier for the masked monomial
// vectors, then an XOR fold of N_IN vectors into N_OUT output shares.
module monomial_compress_pipe #(
  parameter int W     = 15,
  parameter int N_IN  = 8,
  parameter int N_OUT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  monomial_compress_pipe_if.slave bus
);

  logic                 r_vld_p1;
  logic                 r_vld_p2;
  logic [N_IN*W-1:0]    r_data_p1;
  logic [N_OUT*W-1:0]   r_data_p2;

  logic                 w_s2_free;
  logic                 w_s1_move;
  logic                 w_in_ready;
  logic                 w_accept;
  logic [N_OUT*W-1:0]   w_fold;

  // Vector i lands in share i % N_OUT; bitwise XOR only, never carries.
  function automatic logic [N_OUT*W-1:0] xor_compress(input logic [N_IN*W-1:0] v);
    logic [N_OUT*W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N_IN; i++) begin
      acc[(i % N_OUT)*W +: W] = acc[(i % N_OUT)*W +: W] ^ v[i*W +: W];
    end
    return acc;
  endfunction

  assign w_s2_free  = !r_vld_p2 || bus.out_ready;
  assign w_s1_move  = r_vld_p1 && w_s2_free;
  assign w_in_ready = !r_vld_p1 || w_s1_move;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_fold     = xor_compress(r_data_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= w_accept || (r_vld_p1 && !w_s1_move);
      r_vld_p2 <= w_s1_move || (r_vld_p2 && !bus.out_ready);
    end
  end

  // p1: glitch barrier, raw input straight into flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_p1 <= '0;
    end else if (w_accept) begin
      r_data_p1 <= bus.in_vec;
    end
  end

  // p2: compressed shares, driven straight to the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_p2 <= '0;
    end else if (w_s1_move) begin
      r_data_p2 <= w_fold;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_p2;
  assign bus.out_vec   = r_data_p2;
  assign bus.occupancy = {1'b0, r_vld_p1} + {1'b0, r_vld_p2};

endmodule

// File: tb/tb_monomial_compress_pipe.sv
// Directed and random bench for monomial_compress_pipe: a FIFO reference model
// plus per-cycle checks, pinned by hand-computed literal vectors.
module tb_monomial_compress_pipe;
  localparam int W     = 15;
  localparam int N_IN  = 8;
  localparam int N_OUT = 4;
  localparam int VW    = N_IN * W;
  localparam int OW    = N_OUT * W;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  monomial_compress_pipe_if #(.W(W), .N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  monomial_compress_pipe #(.W(W), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Share j is the XOR of every input word whose index is congruent to j.
  function automatic logic [OW-1:0] model(input logic [VW-1:0] v);
    logic [W-1:0] sh [N_OUT];
    logic [OW-1:0] r;
    for (int j = 0; j < N_OUT; j++) sh[j] = '0;
    for (int i = 0; i < N_IN; i++) sh[i % N_OUT] = sh[i % N_OUT] ^ v[i*W +: W];
    for (int j = 0; j < N_OUT; j++) r[j*W +: W] = sh[j];
    return r;
  endfunction

  task automatic rand_vec(output logic [VW-1:0] v);
    for (int i = 0; i < N_IN; i++) v[i*W +: W] = 15'($urandom);
  endtask

  // Reference pipe contents: expected share vector and the cycle it was accepted.
  typedef struct {
    logic [OW-1:0] exp;
    int            t;
  } beat_t;

  beat_t         q[$];
  int            cyc = 0;
  int            rst_cnt = 0;
  int            rst_seen_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_vec = '0;

  always @(negedge rst_n) rst_cnt++;

  always @(negedge clk) begin
    logic exp_ov;
    if (!rst_n || rst_cnt != rst_seen_cnt) begin
      q.delete();
      prev_stall   = 1'b0;
      rst_seen_cnt = rst_cnt;
    end
    if (!rst_n) begin
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_out_vec",   64'(bus.out_vec),   64'(0));
      chk("rst_occupancy", 64'(bus.occupancy), 64'(0));
      chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
    end else begin
      exp_ov = (q.size() > 0) && (cyc - q[0].t >= 2);
      chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
      chk("in_ready",  64'(bus.in_ready),  64'(q.size() < 2 || bus.out_ready));
      chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
      if (bus.out_valid && q.size() > 0) chk("out_vec", 64'(bus.out_vec), 64'(q[0].exp));
      if (prev_stall) chk("stall_hold", 64'(bus.out_vec), 64'(prev_vec));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_vec   = bus.out_vec;
      if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
      if (bus.in_valid && bus.in_ready) q.push_back('{model(bus.in_vec), cyc});
    end
    cyc++;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] v;
    logic [VW-1:0] va;
    logic [VW-1:0] vb;
    logic          acc;

    // T1: reset held with random inputs, then released
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      bus.in_valid  = 1'($urandom);
      rand_vec(v);
      bus.in_vec    = v;
      bus.out_ready = 1'($urandom);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("t1_out_valid", 64'(bus.out_valid), 64'(0));
      chk("t1_occupancy", 64'(bus.occupancy), 64'(0));
      chk("t1_in_ready",  64'(bus.in_ready),  64'(1));
      chk("t1_out_vec",   64'(bus.out_vec),   64'(0));
    end

    // T2: single beat, exact latency and literal result
    v = '0;
    v[0 +: W]   = 15'h7FFF;
    v[4*W +: W] = 15'h0001;
    bus.in_vec   = v;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("t2_ov_after_e0", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    chk("t2_ov_after_e1", 64'(bus.out_valid), 64'(1));
    chk("t2_out_vec",     64'(bus.out_vec),   64'(60'h7FFE));
    @(posedge clk); #1;
    chk("t2_ov_drained",  64'(bus.out_valid), 64'(0));
    chk("t2_occ_drained", 64'(bus.occupancy), 64'(0));

    // T3: backpressure with beats A, B, C
    for (int i = 0; i < N_IN; i++) begin
      va[i*W +: W] = 15'(1 << i);
      vb[i*W +: W] = 15'(i + 1);
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_vec    = va;
    @(posedge clk); #1;
    bus.in_vec = vb;
    @(posedge clk); #1;
    rand_vec(v);
    bus.in_vec = v;
    chk("t3_occ_full",  64'(bus.occupancy), 64'(2));
    chk("t3_in_ready0", 64'(bus.in_ready),  64'(0));
    chk("t3_a_vec",     64'(bus.out_vec),   64'({15'h088, 15'h044, 15'h022, 15'h011}));
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t3_occ_stall",  64'(bus.occupancy), 64'(2));
    chk("t3_ov_stall",   64'(bus.out_valid), 64'(1));
    chk("t3_a_vec_hold", 64'(bus.out_vec),   64'({15'h088, 15'h044, 15'h022, 15'h011}));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("t3_b_vec", 64'(bus.out_vec), 64'({15'h00C, 15'h004, 15'h004, 15'h004}));
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t3_drained", 64'(bus.occupancy), 64'(0));

    // T4: 16 back-to-back beats at full rate
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        bus.in_valid = 1'b1;
        rand_vec(v);
        bus.in_vec = v;
        chk("t4_in_ready", 64'(bus.in_ready), 64'(1));
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("t4_out_valid", 64'(bus.out_valid), 64'(k >= 1 && k <= 16));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // T5: asynchronous reset pulse with two beats in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    rand_vec(v);
    bus.in_vec = v;
    @(posedge clk); #1;
    rand_vec(v);
    bus.in_vec = v;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("t5_occ_full", 64'(bus.occupancy), 64'(2));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t5_ov_async",  64'(bus.out_valid), 64'(0));
    chk("t5_occ_async", 64'(bus.occupancy), 64'(0));
    chk("t5_vec_async", 64'(bus.out_vec),   64'(0));
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("t5_no_stale", 64'(bus.out_valid), 64'(0));
    end

    // T6: random valid/ready stress; producer holds a beat until it is taken
    acc = 1'b0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        rand_vec(v);
        bus.in_vec = v;
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("t6_drained", 64'(bus.occupancy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
